aes_srow_pipe: RTL and testbench
================================

// Module: aes_srow_pipe
// PURPOSE
//  Registered, bidirectional AES/Rijndael row-shift stage: forward ShiftRows or InvShiftRows per transaction.
//  Supports block widths Nb=4/6/8; valid/ready handshake with DEPTH-entry output FIFO and sideband tag.
//  Sits between SubBytes and MixColumns stages of the iterative round datapath (enc and dec share it).
// PARAMETERS
//  NB     4  state columns (4,6,8); any other value -> $error at elaboration
//  DEPTH  2  output FIFO entries (1..4); DEPTH=1 gives a single pipeline register
//  TAG_W  4  width of sideband tag carried with each state
// PORTS
//  clock      in   1        rising-edge clock
//  reset      in   1        synchronous, active-low reset
//  in_valid   in   1        input state valid
//  in_ready   out  1        block can accept; = (count < DEPTH)
//  in_inv     in   1        0 = ShiftRows, 1 = InvShiftRows
//  in_tag     in   TAG_W    sideband, returned unmodified with result
//  in_state   in   8x4*NB   byte array, index 4*col+row (column-major, FIPS-197 order)
//  out_valid  out  1        result valid (= count != 0)
//  out_ready  in   1        consumer accepts
//  out_tag    out  TAG_W    tag of head entry
//  out_state  out  8x4*NB   permuted state of head entry
//  out_par    out  4*NB     [AES_SROW_PARITY_EN only] per-byte even parity, permuted with data
//  par_err    out  1        [AES_SROW_PARITY_EN only] sticky input-parity error
//  in_par     in   4*NB     [AES_SROW_PARITY_EN only] per-byte even parity of in_state
// BEHAVIOUR
//  - Offsets C1,C2,C3: NB=4 -> 1,2,3; NB=6 -> 1,2,3; NB=8 -> 1,3,4. Row 0 never moves.
//  - Forward: out[4j+i] = in[4*((j+Ci)%NB)+i]; inverse: out[4j+i] = in[4*((j+NB-Ci)%NB)+i].
//  - Permutation is applied at push (combinational into FIFO write); FIFO stores permuted data+tag.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both same cycle -> count unchanged.
//  - Latency: state pushed in cycle N is on out_* in cycle N+1 if FIFO was empty; order strictly FIFO.
//  - in_ready depends only on count (no combinational path from out_ready); full -> in_ready=0
//    even if a pop occurs that cycle.
//  - out_* hold stable while out_valid & !out_ready.
//  - Pointers wrap modulo DEPTH; count width $clog2(DEPTH+1).
//  - Reset (reset==0 at edge, any time incl. mid-stream): count=0, rd/wr ptr=0, out_valid=0,
//    in_ready=1 after reset releases (0 while reset low), par_err=0; FIFO contents discarded,
//    storage not cleared, out_state/out_tag don't-care while out_valid=0.
//  - in_inv / in_tag / in_state sampled only on push; ignored otherwise.
// CONFIGURATION
//  AES_SROW_PARITY_EN defined: in_par permuted identically to bytes and stored; out_par valid with
//   out_valid; on push, if any byte's parity != in_par bit, par_err sets and stays 1 until reset;
//   data still forwarded unchanged.
//  Undefined: in_par, out_par, par_err ports absent; no parity storage.
// STRUCTURE
//  - aes_const: NB range check, function srow_off(nb,row) returning Ci; aes_wire: typedef
//    srow_ent_t {tag, state[, par]} for FIFO entry.
//  - Sub-module aes_srow_perm (combinational; params NB; in: state, inv; out: state), instanced
//    twice under AES_SROW_PARITY_EN (data bytes, parity bits via 1-bit-per-byte variant) else once.
//  - Top: FIFO pointers/count, handshake, sticky error flop.
// TESTING
//  - NB=4 fwd, in_state[k]=k: column 0 out = 00 05 0A 0F; column 1 = 04 09 0E 03; 1-cycle latency.
//  - NB=4 inv, same input: column 0 out = 00 0D 0A 07; fwd then inv round trip returns 00..0F.
//  - NB=8 fwd, in[k]=k: out[1]=in[4*1+1]=0x05, out[2]=in[4*3+2]=0x0E, out[3]=in[4*4+3]=0x13.
//  - Backpressure DEPTH=2: out_ready=0, push 3 states -> 2 accepted, in_ready=0, tags 1,2 out in
//    order after out_ready=1; simultaneous push+pop at count=1 keeps count=1.
//  - reset low while count=2 -> next cycle out_valid=0, in_ready=1 after release; no stale data.
//  - PARITY_EN: flip in_par[5] on one push -> par_err=1 next cycle, stays 1; data unchanged.

Source files
------------

// File: rtl/aes_srow_pipe_pkg.sv
// Shared constants and helpers for the AES row-shift stage.
// Latency: none (package only).
// Backpressure: n/a.
// Contents: NB legality check and per-row shift offsets (Rijndael C1..C3).
package aes_srow_pipe_pkg;

    localparam int DEPTH_MAX = 4;

    // Rijndael supports 4, 6 or 8 state columns in this datapath.
    function automatic bit nb_ok(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Left-rotate amount for a row; row 0 never moves, NB=8 uses the wider 1,3,4 offsets.
    function automatic int srow_off(input int nb, input int row);
        case (row)
            0:       return 0;
            1:       return 1;
            2:       return (nb == 8) ? 3 : 2;
            default: return (nb == 8) ? 4 : 3;
        endcase
    endfunction

endpackage

// File: rtl/aes_srow_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation over a column-major state.
// Latency: 0 cycles (pure wiring plus a 2:1 mux per element).
// Backpressure: none; W=8 permutes data bytes, W=1 permutes one parity bit per byte.
// Ports: state_i (element k at [k*W +: W], k = 4*col+row), inv_i (1 = inverse), state_o.
module aes_srow_perm #(
    parameter int NB = 4,
    parameter int W  = 8
) (
    input  logic [4*NB*W-1:0] state_i,
    input  logic              inv_i,
    output logic [4*NB*W-1:0] state_o
);
    import aes_srow_pipe_pkg::*;

    for (genvar j = 0; j < NB; j++) begin : g_col
        for (genvar i = 0; i < 4; i++) begin : g_row
            localparam int OFF   = srow_off(NB, i);
            // Source column for the forward (left rotate) and inverse (right rotate) shifts.
            localparam int SRC_F = (j + OFF) % NB;
            localparam int SRC_I = (j + NB - OFF) % NB;
            assign state_o[(4*j+i)*W +: W] = inv_i ? state_i[(4*SRC_I+i)*W +: W]
                                                   : state_i[(4*SRC_F+i)*W +: W];
        end
    end

endmodule

// File: rtl/aes_srow_pipe.sv
// Registered AES ShiftRows/InvShiftRows stage with a DEPTH-entry output FIFO and sideband tag.
// Latency: 1 cycle from push to out_valid_o when the FIFO is empty; strict FIFO order.
// Backpressure: in_ready_o = (count < DEPTH), registered-count only, no path from out_ready_i.
// Ports: clock_i, reset_i (sync, active-low), in_valid_i/in_ready_o/in_inv_i/in_tag_i/in_state_i,
//        out_valid_o/out_ready_i/out_tag_o/out_state_o; byte k of a state at [8k +: 8], k = 4*col+row.
// Option macro AES_SROW_PARITY_EN: adds in_par_i/out_par_o (per-byte even parity, permuted with
//        the data) and par_err_o (sticky input-parity error, cleared only by reset).
module aes_srow_pipe #(
    parameter int NB    = 4,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               in_inv_i,
    input  logic [TAG_W-1:0]   in_tag_i,
    input  logic [32*NB-1:0]   in_state_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [TAG_W-1:0]   out_tag_o,
    output logic [32*NB-1:0]   out_state_o
`ifdef AES_SROW_PARITY_EN
    ,
    input  logic [4*NB-1:0]    in_par_i,
    output logic [4*NB-1:0]    out_par_o,
    output logic               par_err_o
`endif
);
    import aes_srow_pipe_pkg::*;

    localparam int STATE_W = 32 * NB;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (!nb_ok(NB)) begin : g_bad_nb
        $error("aes_srow_pipe: NB must be 4, 6 or 8");
    end
    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("aes_srow_pipe: DEPTH must be 1..4");
    end

    // FIFO entry: data is stored already permuted.
    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [STATE_W-1:0] state;
`ifdef AES_SROW_PARITY_EN
        logic [4*NB-1:0]    par;
`endif
    } srow_ent_t;

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    srow_ent_t        mem_q [DEPTH];
    srow_ent_t        wr_ent;
    srow_ent_t        rd_ent;
    logic [STATE_W-1:0] perm_state;
    logic             push;
    logic             pop;

    // in_ready_o is forced low while reset is asserted.
    assign in_ready_o  = reset_i && (count_q < CNT_W'(DEPTH));
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    aes_srow_perm #(.NB(NB), .W(8)) u_perm_dat (
        .state_i (in_state_i),
        .inv_i   (in_inv_i),
        .state_o (perm_state)
    );

`ifdef AES_SROW_PARITY_EN
    logic [4*NB-1:0] perm_par;
    logic [4*NB-1:0] calc_par;
    logic            par_bad;
    logic            par_err_q, par_err_d;

    // Parity bits follow their bytes through the same permutation.
    aes_srow_perm #(.NB(NB), .W(1)) u_perm_par (
        .state_i (in_par_i),
        .inv_i   (in_inv_i),
        .state_o (perm_par)
    );

    always_comb begin
        calc_par = '0;
        for (int k = 0; k < 4*NB; k++) begin
            calc_par[k] = ^in_state_i[8*k +: 8];
        end
    end

    assign par_bad   = |(calc_par ^ in_par_i);
    assign par_err_d = par_err_q || (push && par_bad);
    assign par_err_o = par_err_q;
`endif

    always_comb begin
        wr_ent       = '0;
        wr_ent.tag   = in_tag_i;
        wr_ent.state = perm_state;
`ifdef AES_SROW_PARITY_EN
        wr_ent.par   = perm_par;
`endif
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
`ifdef AES_SROW_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
`ifdef AES_SROW_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    // Storage is not reset: entries are only meaningful while counted.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_ent;
        end
    end

    assign rd_ent      = mem_q[rd_ptr_q];
    assign out_tag_o   = rd_ent.tag;
    assign out_state_o = rd_ent.state;
`ifdef AES_SROW_PARITY_EN
    assign out_par_o   = rd_ent.par;
`endif

endmodule

// File: tb/tb_aes_srow_pipe.sv
// Bench for aes_srow_pipe: NB=4 and NB=8 instances, scoreboard of expected permuted states.
// Latency: n/a.
// Backpressure: exercised with random and held out_ready.
module tb_aes_srow_pipe;

    typedef struct {
        logic [3:0]   tag;
        logic [255:0] st;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         v4 = 1'b0, rdy4, inv4 = 1'b0, ov4, ordy4 = 1'b0;
    logic [3:0]   tag4 = '0, otag4;
    logic [127:0] st4 = '0, ost4;

    logic         v8 = 1'b0, rdy8, inv8 = 1'b0, ov8, ordy8 = 1'b0;
    logic [3:0]   tag8 = '0, otag8;
    logic [255:0] st8 = '0, ost8;

    int checks   = 0;
    int failures = 0;
    exp_t sb4[$];

    always #5 clk = ~clk;

`ifdef AES_SROW_PARITY_EN
    logic [15:0] par4, opar4, par_flip = '0;
    logic        perr4;
    logic [31:0] par8, opar8;
    logic        perr8;
    always_comb begin
        for (int k = 0; k < 16; k++) par4[k] = (^st4[8*k +: 8]) ^ par_flip[k];
        for (int k = 0; k < 32; k++) par8[k] = ^st8[8*k +: 8];
    end
`endif

    aes_srow_pipe #(.NB(4), .DEPTH(2), .TAG_W(4)) dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .in_valid_i  (v4),
        .in_ready_o  (rdy4),
        .in_inv_i    (inv4),
        .in_tag_i    (tag4),
        .in_state_i  (st4),
        .out_valid_o (ov4),
        .out_ready_i (ordy4),
        .out_tag_o   (otag4),
        .out_state_o (ost4)
`ifdef AES_SROW_PARITY_EN
        ,
        .in_par_i    (par4),
        .out_par_o   (opar4),
        .par_err_o   (perr4)
`endif
    );

    aes_srow_pipe #(.NB(8), .DEPTH(2), .TAG_W(4)) dut8 (
        .clock_i     (clk),
        .reset_i     (rst),
        .in_valid_i  (v8),
        .in_ready_o  (rdy8),
        .in_inv_i    (inv8),
        .in_tag_i    (tag8),
        .in_state_i  (st8),
        .out_valid_o (ov8),
        .out_ready_i (ordy8),
        .out_tag_o   (otag8),
        .out_state_o (ost8)
`ifdef AES_SROW_PARITY_EN
        ,
        .in_par_i    (par8),
        .out_par_o   (opar8),
        .par_err_o   (perr8)
`endif
    );

    // Reference: FIPS-197 row rotation with Rijndael offsets.
    function automatic logic [255:0] model(input int nb, input bit inv, input logic [255:0] s);
        int off [4];
        int src;
        logic [255:0] r;
        r = '0;
        off[0] = 0; off[1] = 1;
        off[2] = (nb == 8) ? 3 : 2;
        off[3] = (nb == 8) ? 4 : 3;
        for (int j = 0; j < nb; j++) begin
            for (int i = 0; i < 4; i++) begin
                src = inv ? (j + nb - off[i]) % nb : (j + off[i]) % nb;
                r[8*(4*j+i) +: 8] = s[8*(4*src+i) +: 8];
            end
        end
        return r;
    endfunction

    // One clock for the NB=4 instance: record push into scoreboard, report pop and its data.
    task automatic step4(output bit popped, output logic [3:0] ptag, output logic [127:0] pst);
        exp_t e;
        #1;
        if (v4 && rdy4) begin
            e.tag = tag4;
            e.st  = model(4, inv4, {128'b0, st4});
            sb4.push_back(e);
        end
        popped = ov4 && ordy4;
        ptag   = otag4;
        pst    = ost4;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ov4 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov4); end
        checks++;
        if (rdy4 !== 1'b0) begin failures++; $display("FAIL reset_in_ready_low got=%b exp=0", rdy4); end
        rst = 1'b1;
        #1;
        checks++;
        if (rdy4 !== 1'b1 || rdy8 !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready_rel got=%b/%b exp=1/1", rdy4, rdy8);
        end
        checks++;
        if (ov4 !== 1'b0 || ov8 !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid_rel got=%b/%b exp=0/0", ov4, ov8);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fwd_inv_nb4;
        logic [127:0] ramp, fwd_c, inv_c, s;
        logic [3:0]   t;
        bit           p;
        exp_t         e;
        for (int k = 0; k < 16; k++) ramp[8*k +: 8] = 8'(k);
        fwd_c = 128'h0B06010C_07020D08_030E0904_0F0A0500;
        inv_c = 128'h0306090C_0F020508_0B0E0104_070A0D00;
        // forward, inverse, then inverse of the forward result
        for (int n = 0; n < 3; n++) begin
            st4   = (n == 2) ? fwd_c : ramp;
            inv4  = (n != 0);
            tag4  = 4'(n + 3);
            v4    = 1'b1;
            ordy4 = 1'b1;
            step4(p, t, s);
            v4 = 1'b0;
            checks++;
            if (ov4 !== 1'b1) begin failures++; $display("FAIL latency_nb4 n=%0d got=%b exp=1", n, ov4); end
            step4(p, t, s);
            checks++;
            if (!p || sb4.size() == 0) begin
                failures++; $display("FAIL pop_nb4 n=%0d popped=%0d sb=%0d", n, p, sb4.size());
            end else begin
                e = sb4.pop_front();
                checks++;
                if (s !== e.st[127:0] || t !== e.tag) begin
                    failures++; $display("FAIL sb_nb4 n=%0d got=%h/%h exp=%h/%h", n, t, s, e.tag, e.st[127:0]);
                end
                checks++;
                if (s !== ((n == 0) ? fwd_c : (n == 1) ? inv_c : ramp)) begin
                    failures++; $display("FAIL const_nb4 n=%0d got=%h", n, s);
                end
            end
        end
        checks++;
        if (ov4 !== 1'b0) begin failures++; $display("FAIL empty_nb4 got=%b exp=0", ov4); end
    endtask

    task automatic test_nb8;
        logic [255:0] ramp, first;
        for (int k = 0; k < 32; k++) ramp[8*k +: 8] = 8'(k);
        first = '0;
        for (int n = 0; n < 2; n++) begin
            st8   = (n == 0) ? ramp : first;
            inv8  = (n == 1);
            tag8  = 4'hA + 4'(n);
            v8    = 1'b1;
            ordy8 = 1'b1;
            #1;
            checks++;
            if (rdy8 !== 1'b1) begin failures++; $display("FAIL nb8_in_ready got=%b exp=1", rdy8); end
            @(posedge clk);
            #1;
            v8 = 1'b0;
            checks++;
            if (ov8 !== 1'b1 || otag8 !== 4'hA + 4'(n)) begin
                failures++; $display("FAIL nb8_valid n=%0d got=%b/%h", n, ov8, otag8);
            end
            checks++;
            if (ost8 !== model(8, n == 1, st8)) begin
                failures++; $display("FAIL nb8_state n=%0d got=%h exp=%h", n, ost8, model(8, n == 1, st8));
            end
            if (n == 0) begin
                checks++;
                if (ost8[15:8] !== 8'h05 || ost8[23:16] !== 8'h0E || ost8[31:24] !== 8'h13) begin
                    failures++; $display("FAIL nb8_bytes got=%h exp=130E05", ost8[31:8]);
                end
                first = ost8;
            end else begin
                checks++;
                if (ost8 !== ramp) begin failures++; $display("FAIL nb8_roundtrip got=%h", ost8); end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (ov8 !== 1'b0) begin failures++; $display("FAIL nb8_empty got=%b exp=0", ov8); end
    endtask

    task automatic test_backpressure;
        logic [127:0] s, hold_s;
        logic [3:0]   t, hold_t;
        bit           p;
        exp_t         e;
        ordy4 = 1'b0;
        inv4  = 1'b0;
        v4    = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tag4 = 4'(k);
            st4  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            checks++;
            if (rdy4 !== (k <= 2)) begin failures++; $display("FAIL bp_in_ready k=%0d got=%b", k, rdy4); end
            step4(p, t, s);
        end
        v4 = 1'b0;
        hold_t = otag4;
        hold_s = ost4;
        step4(p, t, s);
        checks++;
        if (otag4 !== 4'd1 || hold_t !== 4'd1 || ost4 !== hold_s) begin
            failures++; $display("FAIL bp_hold got=%h/%h exp tag=1", otag4, ost4);
        end
        ordy4 = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            step4(p, t, s);
            checks++;
            if (!p || sb4.size() == 0) begin
                failures++; $display("FAIL bp_pop k=%0d popped=%0d", k, p);
            end else begin
                e = sb4.pop_front();
                checks++;
                if (t !== 4'(k) || t !== e.tag || s !== e.st[127:0]) begin
                    failures++; $display("FAIL bp_order k=%0d got=%h/%h exp=%h/%h", k, t, s, e.tag, e.st[127:0]);
                end
            end
        end
        checks++;
        if (ov4 !== 1'b0 || sb4.size() != 0) begin
            failures++; $display("FAIL bp_drained got=%b sb=%0d", ov4, sb4.size());
        end
        // push + pop in the same cycle at count 1
        ordy4 = 1'b0; v4 = 1'b1; tag4 = 4'd5; st4 = {4{$urandom}};
        step4(p, t, s);
        ordy4 = 1'b1; tag4 = 4'd6; st4 = {4{$urandom}};
        step4(p, t, s);
        v4 = 1'b0;
        checks++;
        if (!p || t !== 4'd5) begin failures++; $display("FAIL pp_pop got=%0d/%h exp=1/5", p, t); end
        if (sb4.size() != 0) void'(sb4.pop_front());
        checks++;
        if (ov4 !== 1'b1 || rdy4 !== 1'b1 || otag4 !== 4'd6) begin
            failures++; $display("FAIL pp_count1 got v=%b r=%b tag=%h exp 1/1/6", ov4, rdy4, otag4);
        end
        step4(p, t, s);
        checks++;
        if (!p || sb4.size() == 0) begin
            failures++; $display("FAIL pp_last popped=%0d", p);
        end else begin
            e = sb4.pop_front();
            if (t !== e.tag || s !== e.st[127:0]) begin
                failures++; $display("FAIL pp_last_data got=%h/%h exp=%h/%h", t, s, e.tag, e.st[127:0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] s;
        logic [3:0]   t;
        bit           p;
        exp_t         e;
        for (int c = 0; c < 80; c++) begin
            v4    = 1'($urandom_range(0, 1));
            ordy4 = ($urandom_range(0, 3) != 0);
            inv4  = 1'($urandom_range(0, 1));
            tag4  = 4'($urandom);
            st4   = {$urandom, $urandom, $urandom, $urandom};
            step4(p, t, s);
            if (p) begin
                checks++;
                if (sb4.size() == 0) begin
                    failures++; $display("FAIL b2b_unexpected cycle=%0d tag=%h", c, t);
                end else begin
                    e = sb4.pop_front();
                    if (t !== e.tag || s !== e.st[127:0]) begin
                        failures++; $display("FAIL b2b_data cycle=%0d got=%h/%h exp=%h/%h", c, t, s, e.tag, e.st[127:0]);
                    end
                end
            end
        end
        v4 = 1'b0;
        ordy4 = 1'b1;
        for (int c = 0; c < 10 && sb4.size() != 0; c++) begin
            step4(p, t, s);
            if (p) begin
                e = sb4.pop_front();
                checks++;
                if (t !== e.tag || s !== e.st[127:0]) begin
                    failures++; $display("FAIL b2b_drain got=%h/%h exp=%h/%h", t, s, e.tag, e.st[127:0]);
                end
            end
        end
        checks++;
        if (sb4.size() != 0 || ov4 !== 1'b0) begin
            failures++; $display("FAIL b2b_timeout left=%0d valid=%b", sb4.size(), ov4);
        end
    endtask

    task automatic test_reset_midstream;
        logic [127:0] s;
        logic [3:0]   t;
        bit           p;
        exp_t         e;
        ordy4 = 1'b0; v4 = 1'b1; inv4 = 1'b0;
        for (int k = 7; k <= 8; k++) begin
            tag4 = 4'(k);
            st4  = {4{$urandom}};
            step4(p, t, s);
        end
        v4 = 1'b0;
        checks++;
        if (rdy4 !== 1'b0 || ov4 !== 1'b1) begin
            failures++; $display("FAIL mid_full got r=%b v=%b exp 0/1", rdy4, ov4);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ov4 !== 1'b0 || rdy4 !== 1'b0) begin
            failures++; $display("FAIL mid_reset got v=%b r=%b exp 0/0", ov4, rdy4);
        end
        rst = 1'b1;
        sb4.delete();
        #1;
        checks++;
        if (rdy4 !== 1'b1 || ov4 !== 1'b0) begin
            failures++; $display("FAIL mid_release got r=%b v=%b exp 1/0", rdy4, ov4);
        end
        v4 = 1'b1; ordy4 = 1'b1; tag4 = 4'd9; st4 = {4{$urandom}};
        step4(p, t, s);
        v4 = 1'b0;
        step4(p, t, s);
        checks++;
        if (!p || sb4.size() == 0) begin
            failures++; $display("FAIL mid_pop popped=%0d", p);
        end else begin
            e = sb4.pop_front();
            if (t !== 4'd9 || s !== e.st[127:0]) begin
                failures++; $display("FAIL mid_stale got=%h/%h exp=9/%h", t, s, e.st[127:0]);
            end
        end
    endtask

`ifdef AES_SROW_PARITY_EN
    task automatic test_parity;
        logic [127:0] s, exp_s;
        logic [3:0]   t;
        bit           p;
        checks++;
        if (perr4 !== 1'b0) begin failures++; $display("FAIL par_clean got=%b exp=0", perr4); end
        ordy4 = 1'b1; v4 = 1'b1; inv4 = 1'b0; tag4 = 4'hC;
        st4 = {4{$urandom}};
        exp_s = model(4, 1'b0, {128'b0, st4})[127:0];
        par_flip = 16'h0020;
        step4(p, t, s);
        v4 = 1'b0;
        par_flip = '0;
        checks++;
        if (perr4 !== 1'b1 || ost4 !== exp_s) begin
            failures++; $display("FAIL par_set got=%b/%h exp=1/%h", perr4, ost4, exp_s);
        end
        step4(p, t, s);
        step4(p, t, s);
        checks++;
        if (perr4 !== 1'b1) begin failures++; $display("FAIL par_sticky got=%b exp=1", perr4); end
        sb4.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_fwd_inv_nb4();
        test_nb8();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
`ifdef AES_SROW_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
